prog_mem: RTL and testbench

- Parametrised, synchronous program memory for the washing register machine.
- Successor to the fixed 8-bit-pc / 16-bit-instr combinational ROM.
- Adds a byte-serial program load port, a LOAD/RUN state machine and a registered fetch with valid handshake.
- Sits between the external loader (UART/boot source) and the core's fetch stage.

---
 rtl/prog_mem_if.sv | 25 ++
 rtl/prog_mem.sv | 75 +++++++
 tb/tb_prog_mem.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch and byte-serial load bus between loader/core and program memory
interface prog_mem_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  pc;
  logic               fetch_req;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               load_start;
  logic               load_valid;
  logic [7:0]         load_byte;
  logic               load_end;
  logic               busy;
  logic               load_err;
  logic [ADDR_W:0]    loaded_words;
  modport master (
    output pc, fetch_req, load_start, load_valid, load_byte, load_end,
    input  instr, instr_valid, busy, load_err, loaded_words
  );
  modport slave (
    input  pc, fetch_req, load_start, load_valid, load_byte, load_end,
    output instr, instr_valid, busy, load_err, loaded_words
  );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: synchronous program memory with byte-serial LOAD/RUN loader and registered fetch
module prog_mem #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input logic         clk,
  input logic         rst,
  prog_mem_if.slave   bus
);
  localparam int BYTES = INSTR_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(BYTES + 1);
  localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
  typedef enum logic {RUN, LOAD} state_t;
  state_t             state, state_n;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] asm_r, asm_a, wdata;
  logic [CW-1:0]      cnt, cnt_a;
  logic [ADDR_W:0]    lw;
  logic               err, full, acc, wr_full, ending, pad_pend, we;
  assign full     = lw[ADDR_W];
  assign bus.busy = (state == LOAD);
  assign bus.load_err     = err;
  assign bus.loaded_words = lw;
  // byte acceptance, word completion and end-of-load padding; the byte of this cycle is merged before termination
  always_comb begin
    acc      = (state == LOAD) && bus.load_valid && !full;
    cnt_a    = acc ? cnt + CW'(1) : cnt;
    asm_a    = acc ? INSTR_W'({asm_r, bus.load_byte}) : asm_r;
    wr_full  = acc && (cnt_a == BYTES_C);
    ending   = (state == LOAD) && bus.load_end && !bus.load_start;
    pad_pend = ending && !wr_full && (cnt_a != '0);
    we       = wr_full || (pad_pend && !full);
    wdata    = asm_a << (8 * (BYTES - int'(cnt_a)));
  end
  // LOAD/RUN next state; load_start wins over load_end
  always_comb begin
    state_n = state;
    state_n = bus.load_start ? LOAD : ending ? RUN : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  // loader counters, assembly register and sticky overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      asm_r <= '0;
      lw    <= '0;
      err   <= 1'b0;
    end else if (bus.load_start) begin
      cnt   <= '0;
      asm_r <= '0;
      lw    <= '0;
      err   <= 1'b0;
    end else if (state == LOAD) begin
      cnt   <= (we || ending) ? '0 : cnt_a;
      asm_r <= asm_a;
      lw    <= lw + (ADDR_W+1)'(we);
      err   <= err || (bus.load_valid && full) || (pad_pend && full);
    end
  // memory array write port; contents deliberately survive reset
  always_ff @(posedge clk)
    if (we) mem[lw[ADDR_W-1:0]] <= wdata;
  // registered fetch, only in RUN and not on the cycle a load begins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      bus.instr_valid <= (state == RUN) && bus.fetch_req && !bus.load_start;
      if ((state == RUN) && bus.fetch_req && !bus.load_start) bus.instr <= mem[bus.pc];
    end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed scoreboard bench for prog_mem
module tb_prog_mem;
  localparam int AW = 2;
  localparam int IW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [IW-1:0] sb[$];
  logic [IW-1:0] exp_w;
  prog_mem_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();
  prog_mem #(.ADDR_W(AW), .INSTR_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    cyc();
    bus.load_valid = 1'b0;
  endtask
  task automatic pulse_start();
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
  endtask
  task automatic pulse_end();
    bus.load_end = 1'b1;
    cyc();
    bus.load_end = 1'b0;
  endtask
  task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] e);
    bus.fetch_req = 1'b1;
    bus.pc = a;
    sb.push_back(e);
    cyc();
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    exp_w = sb.pop_front();
    chk(tag, 32'(bus.instr), 32'(exp_w));
  endtask
  initial begin
    bus.pc = '0;
    bus.fetch_req = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte = '0;
    bus.load_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.load_err), 32'd0);
    chk("rst_lw", 32'(bus.loaded_words), 32'd0);
    rst = 1'b0;
    cyc();
    pulse_start();
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_lw0", 32'(bus.loaded_words), 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    pulse_end();
    chk("full_lw", 32'(bus.loaded_words), 32'd2);
    chk("full_busy", 32'(bus.busy), 32'd0);
    chk("full_err", 32'(bus.load_err), 32'd0);
    fetch("f_pc0", 2'd0, 16'h1234);
    fetch("f_pc1", 2'd1, 16'h5678);
    fetch("b2b_0", 2'd0, 16'h1234);
    fetch("b2b_1", 2'd1, 16'h5678);
    fetch("b2b_2", 2'd0, 16'h1234);
    bus.fetch_req = 1'b0;
    cyc();
    chk("drop_valid", 32'(bus.instr_valid), 32'd0);
    chk("drop_hold", 32'(bus.instr), 32'h1234);
    pulse_start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    pulse_end();
    chk("part_lw", 32'(bus.loaded_words), 32'd2);
    fetch("part_pc1", 2'd1, 16'hEF00);
    fetch("part_pc0", 2'd0, 16'hABCD);
    bus.fetch_req = 1'b1;
    bus.pc = 2'd0;
    pulse_start();
    chk("blk_valid0", 32'(bus.instr_valid), 32'd0);
    chk("blk_hold", 32'(bus.instr), 32'hABCD);
    send_byte(8'h11);
    chk("blk_valid1", 32'(bus.instr_valid), 32'd0);
    bus.load_end = 1'b1;
    send_byte(8'h22);
    bus.load_end = 1'b0;
    chk("blk_valid2", 32'(bus.instr_valid), 32'd0);
    chk("sim_lw", 32'(bus.loaded_words), 32'd1);
    chk("sim_busy", 32'(bus.busy), 32'd0);
    fetch("sim_pc0", 2'd0, 16'h1122);
    fetch("sim_pc1", 2'd1, 16'hEF00);
    bus.fetch_req = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    chk("ovf_lw4", 32'(bus.loaded_words), 32'd4);
    chk("ovf_err0", 32'(bus.load_err), 32'd0);
    send_byte(8'h18);
    chk("ovf_err1", 32'(bus.load_err), 32'd1);
    chk("ovf_busy", 32'(bus.busy), 32'd1);
    for (int i = 9; i < 18; i++) send_byte(8'(8'h10 + i));
    pulse_end();
    chk("ovf_end_busy", 32'(bus.busy), 32'd0);
    chk("ovf_end_err", 32'(bus.load_err), 32'd1);
    chk("ovf_end_lw", 32'(bus.loaded_words), 32'd4);
    for (int w = 0; w < 4; w++) fetch("ovf_word", AW'(w), {8'(8'h10 + 2 * w), 8'(8'h11 + 2 * w)});
    bus.fetch_req = 1'b0;
    pulse_start();
    chk("restart_err", 32'(bus.load_err), 32'd0);
    chk("restart_lw", 32'(bus.loaded_words), 32'd0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    chk("pre_rst_lw", 32'(bus.loaded_words), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_err", 32'(bus.load_err), 32'd0);
    chk("arst_lw", 32'(bus.loaded_words), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_end();
    chk("run_end_busy", 32'(bus.busy), 32'd0);
    bus.load_valid = 1'b1;
    bus.load_byte = 8'h55;
    cyc();
    bus.load_valid = 1'b0;
    chk("run_valid_lw", 32'(bus.loaded_words), 32'd0);
    fetch("arst_pc0", 2'd0, 16'hA1B2);
    fetch("arst_pc1", 2'd1, 16'h1213);
    bus.fetch_req = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
